// File: rtl/dmem_bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_bus_ctrl_pkg
// Shared definitions for the MEM-stage data-memory bus controller:
//   - state encoding (IDLE / BUSY / DONE) and the matching enum type
//   - mask that forces a byte address onto a word boundary
//   - popcount helper used to classify store byte-enable patterns
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_bus_ctrl_pkg;

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] BUSY_ENC = 2'd1;
    localparam logic [1:0] DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE_ENC,
        ST_BUSY = BUSY_ENC,
        ST_DONE = DONE_ENC
    } state_t;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // Number of active byte lanes in a 4-bit enable pattern.
    function automatic logic [2:0] be_popcount(input logic [3:0] be);
        be_popcount = {2'b00, be[0]} + {2'b00, be[1]} + {2'b00, be[2]} + {2'b00, be[3]};
    endfunction

endpackage

// File: rtl/dmem_bus_ctrl_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational store-data lane replication. The store data arrives
// right-justified (rt value); memory picks bytes by lane, so sub-word stores
// are replicated across all lanes and the byte enables select the live ones.
// Ports:
//   i_be      [3:0]  store byte enables
//   i_wdata   [31:0] right-justified store data
//   o_aligned [31:0] lane-aligned store data
// -----------------------------------------------------------------------------
module dmem_lane_align (
    input  logic [3:0]  i_be,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_aligned
);
    import dmem_bus_ctrl_pkg::*;

    logic [2:0] w_laneCount;

    assign w_laneCount = be_popcount(i_be);

    // One lane replicates the low byte, two lanes replicate the low halfword.
    // Full words and any odd pattern pass the data through untouched.
    always_comb begin
        o_aligned = i_wdata;
        case (w_laneCount)
            3'd1:    o_aligned = {4{i_wdata[7:0]}};
            3'd2:    o_aligned = {2{i_wdata[15:0]}};
            default: o_aligned = i_wdata;
        endcase
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_bus_ctrl
// MEM-stage data-memory bus controller. Accepts a load/store from the pipeline,
// runs one req/ack bus transaction, lane-aligns store data, captures load data
// and stalls the pipeline until the access completes or times out.
// Ports:
//   i_clk, i_reset        clock; synchronous active-low reset
//   i_mem_req/we/addr/wdata/be   MEM-stage access (held while o_stall)
//   o_stall               freeze upstream pipeline registers
//   o_rdata               raw load word, valid in DONE
//   o_bus_err             one-cycle pulse in DONE after a timeout
//   o_bus_req/we/addr/be/wdata   registered bus request
//   i_bus_ack, i_bus_rdata       bus completion strobe and read data
// -----------------------------------------------------------------------------
module dmem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_req,
    input  logic        i_mem_we,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_mem_be,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);
    import dmem_bus_ctrl_pkg::*;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [7:0]  r_waitCnt;
    logic        r_busReq;
    logic        r_busWe;
    logic [31:0] r_busAddr;
    logic [3:0]  r_busBe;
    logic [31:0] r_busWdata;
    logic [31:0] r_rdata;
    logic        r_busErr;
    logic        w_accept;
    logic        w_noopStore;
    logic        w_ack;
    logic        w_timeout;
    logic [31:0] w_aligned;

    dmem_lane_align u_lane_align (
        .i_be      (i_mem_be),
        .i_wdata   (i_mem_wdata),
        .o_aligned (w_aligned)
    );

    // State register. Reset abandons any in-flight transaction.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the one-cycle event strobes the datapath uses.
    // Ack is only honoured in BUSY and takes priority over the timeout when
    // both land on the same cycle. A store with no enabled lanes skips the bus.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_noopStore = 1'b0;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_mem_req) begin
                    w_accept    = 1'b1;
                    w_noopStore = i_mem_we && (i_mem_be == 4'b0000);
                    w_nextState = w_noopStore ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_bus_ack) begin
                    w_ack       = 1'b1;
                    w_nextState = ST_DONE;
                end else if (r_waitCnt == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Bus registers, wait counter and load-data capture. The bus_* fields are
    // written only on acceptance so they stay stable for the whole BUSY phase.
    // The error flag is a pure copy of the timeout strobe, which makes it a
    // single-cycle pulse lined up with DONE.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_waitCnt  <= 8'd0;
            r_busReq   <= 1'b0;
            r_busWe    <= 1'b0;
            r_busAddr  <= 32'd0;
            r_busBe    <= 4'd0;
            r_busWdata <= 32'd0;
            r_rdata    <= 32'd0;
            r_busErr   <= 1'b0;
        end else begin
            r_busErr <= w_timeout;
            if (w_accept) begin
                r_waitCnt  <= 8'd0;
                r_busReq   <= !w_noopStore;
                r_busWe    <= i_mem_we;
                r_busAddr  <= i_mem_addr & WORD_ALIGN_MASK;
                r_busBe    <= i_mem_we ? i_mem_be : 4'b1111;
                r_busWdata <= w_aligned;
            end
            if ((r_state == ST_BUSY) && !w_ack && !w_timeout) begin
                r_waitCnt <= r_waitCnt + 8'd1;
            end
            if (w_ack || w_timeout) begin
                r_busReq <= 1'b0;
            end
            if (w_ack && !r_busWe) begin
                r_rdata <= i_bus_rdata;
            end
            if (w_timeout) begin
                r_rdata <= 32'd0;
            end
        end
    end

    // The pipeline runs free only in DONE, so a held request is not replayed.
    assign o_stall     = i_mem_req && (r_state != ST_DONE);
    assign o_rdata     = r_rdata;
    assign o_bus_err   = r_busErr;
    assign o_bus_req   = r_busReq;
    assign o_bus_we    = r_busWe;
    assign o_bus_addr  = r_busAddr;
    assign o_bus_be    = r_busBe;
    assign o_bus_wdata = r_busWdata;

endmodule

// File: doc/dmem_bus_ctrl.md
# dmem_bus_ctrl

Data-memory bus controller for the MEM stage. It sits directly downstream of the store byte-enable generator and takes the MEM-stage access (address, store data, `be`, load/store). It runs a req/ack transaction on the data-memory bus, lane-aligns store data, captures load data and stalls the pipeline until the access completes or times out.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum bus-wait cycles before an access is aborted; legal range 2..255.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge.
- `mem_req` in 1: MEM stage holds a valid load/store; held until `stall` is 0.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_addr` in 32: byte address from ALU.
- `mem_wdata` in 32: unaligned store data (rt value).
- `mem_be` in 4: byte enables from the store byte-enable generator; 0000 for loads.
- `stall` out 1: freeze PC/F/D/E/M pipeline registers.
- `rdata` out 32: raw load word (downstream load extender selects and extends the bytes); valid in DONE.
- `bus_err` out 1: one-cycle pulse in DONE when the access timed out.
- `bus_req` out 1: bus request, registered.
- `bus_we` out 1: bus write, registered.
- `bus_addr` out 32: `{mem_addr[31:2], 2'b00}`, registered.
- `bus_be` out 4: registered; `mem_be` for stores, 1111 for loads.
- `bus_wdata` out 32: lane-aligned store data, registered.
- `bus_ack` in 1: completion strobe from memory, one cycle.
- `bus_rdata` in 32: read data, valid with `bus_ack`.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, `mem_req`=1:
  - Latch the address, `we`, `be` and aligned data into the `bus_*` registers; clear the wait counter.
  - If `mem_we`=1 and `mem_be`=0000, go to DONE without a bus access (no-op store). Otherwise go to BUSY.
- BUSY:
  - `bus_req`=1. All `bus_*` outputs are held stable until ack.
  - On `bus_ack`: capture `bus_rdata` into `rdata` (loads only; stores leave `rdata` unchanged) and go to DONE.
  - Otherwise increment the wait counter. When the counter reaches `TIMEOUT`-1 without ack: set `rdata`=0, flag the error, go to DONE.
- DONE:
  - `stall`=0 for exactly one cycle; `bus_err`=1 if the access timed out.
  - Next state IDLE unconditionally. A `mem_req` seen in DONE is the completed access, not a new one.
- `stall` is combinational: `mem_req && state != DONE`. It is therefore asserted in the same cycle the request appears in IDLE.
- Store lane alignment, chosen by the popcount of `be`:
  - 1 lane: `{4{wdata[7:0]}}`.
  - 2 lanes: `{2{wdata[15:0]}}`.
  - 4 lanes: `wdata`.
  - Any other pattern: `wdata` unchanged.
- `bus_ack` is ignored outside BUSY.

## Timing
- Reset (`reset`=0 at an edge) forces:
  - state IDLE, counter 0;
  - `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0, `rdata`=0, `bus_err`=0.
  - Reset in BUSY abandons the transaction; `bus_req` drops the following cycle.
- Latency, request in IDLE at cycle 0:
  - `bus_req` is high from cycle 1.
  - Ack at cycle N (N≥1) gives DONE at N+1; the pipeline advances at the end of N+1.
  - Minimum access is 3 cycles: request, BUSY with immediate ack, DONE.
- Ack on the same cycle the counter hits `TIMEOUT`-1: ack wins, no error.
- Timeout: BUSY lasts `TIMEOUT` cycles, then DONE with `bus_err`.
- Back-to-back accesses: DONE → IDLE → the new request is accepted in the IDLE cycle. There is one stall-free bubble only in DONE.

## Structure
- Shared package holds:
  - the state encoding localparams (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the word-align mask constant.
- One sub-module is natural: `dmem_lane_align`, purely combinational `be`+`wdata` → aligned data.
- The FSM, counter and output registers live in the top.

## Test plan
- Store word: addr 0x104, wdata 0x11223344, be 1111; ack after 2 BUSY cycles → bus_addr 0x104, bus_be 1111, bus_wdata 0x11223344; stall high for 3 cycles then low 1 cycle.
- Store byte: addr 0x107, wdata 0x000000AB, be 1000, immediate ack → bus_addr 0x104, bus_wdata 0xABABABAB, bus_be 1000; 3-cycle access.
- Load: addr 0x20, be 0000, bus_rdata 0xDEADBEEF with ack → bus_be 1111, rdata 0xDEADBEEF in DONE, bus_err 0.
- Timeout, `TIMEOUT`=4, no ack → bus_req high exactly 4 cycles; DONE with bus_err=1, rdata=0; ack at the 4th cycle instead → no error.
- No-op store be 0000 → bus_req never asserts; IDLE→DONE, stall high 1 cycle.
- Reset low during BUSY → next cycle bus_req=0, state IDLE, all outputs 0; a stray ack afterward is ignored.
